// File: rtl/neuron_accumulator.sv
// Neuron accumulator: bias plus N_TERMS streamed Q2.2 products, saturated to a Q2.2 result.
// Define NEURON_ACC_RELU_EN to clamp negative saturated results to zero (ReLU).
module neuron_accumulator #(
    parameter int unsigned N_TERMS = 16,
    parameter int unsigned ACC_W   = 12
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [3:0] bias,
    input  logic       prod_valid,
    input  logic [3:0] prod,
    output logic       prod_ready,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [3:0] out_data,
    output logic       busy
);

    localparam int unsigned CNT_W = (N_TERMS > 1) ? $clog2(N_TERMS) : 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_TERMS - 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ACCUM = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [3:0]       out_data_q, out_data_d;

    logic             xfer;
    logic [ACC_W-1:0] sum;
    logic [ACC_W-4:0] sum_hi;
    logic             sum_ovf;
    logic [3:0]       sat_val;
    logic [3:0]       result;

    assign xfer = prod_valid && (state_q == ACCUM);
    assign sum  = acc_q + {{(ACC_W-4){prod[3]}}, prod};

    // The sum fits in 4 bits only when bits [ACC_W-1:3] are all copies of the sign.
    assign sum_hi  = sum[ACC_W-1:3];
    assign sum_ovf = !((&sum_hi) || (~|sum_hi));
    assign sat_val = sum_ovf ? (sum[ACC_W-1] ? 4'h8 : 4'h7) : sum[3:0];

`ifdef NEURON_ACC_RELU_EN
    assign result = sat_val[3] ? 4'h0 : sat_val;
`else
    assign result = sat_val;
`endif

    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        count_d    = count_q;
        out_data_d = out_data_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    acc_d   = {{(ACC_W-4){bias[3]}}, bias};
                    count_d = '0;
                    state_d = ACCUM;
                end
            end
            ACCUM: begin
                if (xfer) begin
                    acc_d   = sum;
                    count_d = count_q + CNT_W'(1);
                    if (count_q == LAST_IDX) begin
                        out_data_d = result;
                        state_d    = DONE;
                    end
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            acc_q      <= '0;
            count_q    <= '0;
            out_data_q <= 4'h0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            count_q    <= count_d;
            out_data_q <= out_data_d;
        end
    end

    assign prod_ready = (state_q == ACCUM);
    assign out_valid  = (state_q == DONE);
    assign busy       = (state_q != IDLE);
    assign out_data   = out_data_q;

endmodule

// File: tb/tb_neuron_accumulator.sv
// Directed self-checking bench for neuron_accumulator (N_TERMS=4, ACC_W=8).
// Expected values follow NEURON_ACC_RELU_EN when it is defined for the build.
module tb_neuron_accumulator;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [3:0] bias;
    logic       prod_valid;
    logic [3:0] prod;
    logic       prod_ready;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_data;
    logic       busy;

    int n_cmp = 0;
    int n_err = 0;

`ifdef NEURON_ACC_RELU_EN
    localparam logic [3:0] EXP_NEG_SAT = 4'h0;
    localparam logic [3:0] EXP_NEG4    = 4'h0;
`else
    localparam logic [3:0] EXP_NEG_SAT = 4'h8;
    localparam logic [3:0] EXP_NEG4    = 4'hC;
`endif

    neuron_accumulator #(
        .N_TERMS(4),
        .ACC_W  (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .bias      (bias),
        .prod_valid(prod_valid),
        .prod      (prod),
        .prod_ready(prod_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_start(input logic [3:0] b);
        start = 1'b1;
        bias  = b;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic beat(input logic [3:0] p);
        prod_valid = 1'b1;
        prod       = p;
        @(negedge clk);
        prod_valid = 1'b0;
    endtask

    task automatic consume();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    initial begin
        rst_n      = 1'b0;
        start      = 1'b0;
        bias       = 4'h0;
        prod_valid = 1'b0;
        prod       = 4'h0;
        out_ready  = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rst_prod_ready", {3'b0, prod_ready}, 4'h0);
        check("rst_out_valid", {3'b0, out_valid}, 4'h0);
        check("rst_busy", {3'b0, busy}, 4'h0);
        check("rst_out_data", out_data, 4'h0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_busy", {3'b0, busy}, 4'h0);

        // Basic sum: 0 + 1+1+1+1, with a stray start during accumulation.
        do_start(4'h0);
        check("t1_prod_ready", {3'b0, prod_ready}, 4'h1);
        check("t1_busy", {3'b0, busy}, 4'h1);
        beat(4'h1);
        start = 1'b1;
        bias  = 4'h7;
        beat(4'h1);
        start = 1'b0;
        beat(4'h1);
        check("t1_not_done", {3'b0, out_valid}, 4'h0);
        beat(4'h1);
        check("t1_out_valid", {3'b0, out_valid}, 4'h1);
        check("t1_out_data", out_data, 4'h4);
        check("t1_done_prod_ready", {3'b0, prod_ready}, 4'h0);
        consume();
        check("t1_after_valid", {3'b0, out_valid}, 4'h0);
        check("t1_after_busy", {3'b0, busy}, 4'h0);

        // Positive saturation: 7 + 4*7 = 35.
        do_start(4'h7);
        for (int i = 0; i < 4; i++) beat(4'h7);
        check("t2_pos_sat", out_data, 4'h7);
        consume();

        // Negative saturation: -8 + 4*(-8) = -40.
        do_start(4'h8);
        for (int i = 0; i < 4; i++) beat(4'h8);
        check("t2_neg_sat", out_data, EXP_NEG_SAT);
        consume();

        // In-range negative: 4*(-1) = -4.
        do_start(4'h0);
        for (int i = 0; i < 4; i++) beat(4'hF);
        check("t3_neg4", out_data, EXP_NEG4);
        consume();

        // Gapped beats: valid pattern 1,0,0,1,1,0,1 of 2s; idle cycles carry junk data.
        do_start(4'h0);
        beat(4'h2);
        prod = 4'h7; @(negedge clk);
        prod = 4'h7; @(negedge clk);
        beat(4'h2);
        beat(4'h2);
        prod = 4'h7; @(negedge clk);
        check("t4_gap_not_done", {3'b0, out_valid}, 4'h0);
        check("t4_gap_ready", {3'b0, prod_ready}, 4'h1);
        beat(4'h2);
        check("t4_out_valid", {3'b0, out_valid}, 4'h1);
        check("t4_out_data", out_data, 4'h7);
        // Back-pressure: hold result while start and prod_valid are noise.
        start      = 1'b1;
        bias       = 4'h1;
        prod_valid = 1'b1;
        prod       = 4'h1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t4_hold_valid", {3'b0, out_valid}, 4'h1);
            check("t4_hold_data", out_data, 4'h7);
            check("t4_hold_ready", {3'b0, prod_ready}, 4'h0);
        end
        // Handshake and start together: handshake wins, start ignored.
        out_ready = 1'b1;
        @(negedge clk);
        out_ready  = 1'b0;
        start      = 1'b0;
        prod_valid = 1'b0;
        check("t4_hs_valid", {3'b0, out_valid}, 4'h0);
        check("t4_hs_busy", {3'b0, busy}, 4'h0);
        @(negedge clk);
        check("t4_idle_busy", {3'b0, busy}, 4'h0);

        // Asynchronous reset mid-accumulation, then a fresh evaluation.
        do_start(4'h3);
        beat(4'h3);
        beat(4'h3);
        #2;
        rst_n = 1'b0;
        #1;
        check("t5_rst_busy", {3'b0, busy}, 4'h0);
        check("t5_rst_prod_ready", {3'b0, prod_ready}, 4'h0);
        check("t5_rst_out_valid", {3'b0, out_valid}, 4'h0);
        check("t5_rst_out_data", out_data, 4'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("t5_post_valid", {3'b0, out_valid}, 4'h0);
        check("t5_post_busy", {3'b0, busy}, 4'h0);
        do_start(4'h1);
        for (int i = 0; i < 4; i++) beat(4'h1);
        check("t5_out_valid", {3'b0, out_valid}, 4'h1);
        check("t5_out_data", out_data, 4'h5);
        consume();
        check("t5_end_valid", {3'b0, out_valid}, 4'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
